// File: rtl/alu_flag_branch_unit.sv
// rtl/alu_flag_branch_unit.sv - NZCV flag register and branch resolver on the ALU result interface
module alu_flag_branch_unit #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [2:0]        ctrl,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] C,
    input  logic              zero,
    input  logic              set_flags,
    input  logic [1:0]        br_type,
    input  logic [3:0]        cond,
    output logic              valid_out,
    output logic              branch_taken,
    output logic [3:0]        flags_out,
    output logic [CNT_W-1:0]  taken_count,
    output logic              ctrl_err
);
    localparam int M = DATA_W - 1;

    logic       am, bm, cm;
    logic       op_c, op_v;
    logic [3:0] op_flags;
    logic       ctrl_ok;
    logic       fn, fz, fc, fv;
    logic       cond_true;
    logic       taken_d;
    logic       unused_low_bits;

    assign am = A[M];
    assign bm = B[M];
    assign cm = C[M];
    assign unused_low_bits = ^{A[M-1:0], B[M-1:0], C[M-1:0]};

    always_comb begin
        op_c = 1'b0;
        op_v = 1'b0;
        case (ctrl)
            3'b000: begin
                op_c = (am & bm) | ((am | bm) & ~cm);
                op_v = (am == bm) & (cm != am);
            end
            3'b001: begin
                // Carry means "no borrow", matching ARM subtract semantics
                op_c = (am & ~bm) | ((am | ~bm) & ~cm);
                op_v = (am != bm) & (cm != am);
            end
            default: ;
        endcase
    end

    assign op_flags = {cm, zero, op_c, op_v};
    assign ctrl_ok  = (ctrl <= 3'd4);

    // B.cond sees the register contents before this cycle's flag update
    assign {fn, fz, fc, fv} = flags_out;

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            4'h0: cond_true = fz;
            4'h1: cond_true = ~fz;
            4'h2: cond_true = fc;
            4'h3: cond_true = ~fc;
            4'h4: cond_true = fn;
            4'h5: cond_true = ~fn;
            4'h6: cond_true = fv;
            4'h7: cond_true = ~fv;
            4'h8: cond_true = fc & ~fz;
            4'h9: cond_true = ~(fc & ~fz);
            4'hA: cond_true = (fn == fv);
            4'hB: cond_true = (fn != fv);
            4'hC: cond_true = ~fz & (fn == fv);
            4'hD: cond_true = ~(~fz & (fn == fv));
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        taken_d = 1'b0;
        if (valid_in) begin
            case (br_type)
                2'b01:   taken_d = zero;
                2'b10:   taken_d = ~zero;
                2'b11:   taken_d = cond_true;
                default: taken_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out    <= 1'b0;
            branch_taken <= 1'b0;
            flags_out    <= 4'b0000;
            taken_count  <= '0;
            ctrl_err     <= 1'b0;
        end else begin
            valid_out    <= valid_in;
            branch_taken <= taken_d;
            if (taken_d && (taken_count != {CNT_W{1'b1}}))
                taken_count <= taken_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (valid_in && set_flags) begin
                if (ctrl_ok)
                    flags_out <= op_flags;
                else
                    ctrl_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// tb/tb_alu_flag_branch_unit.sv - directed-vector bench with a behavioural flag/branch model
module tb_alu_flag_branch_unit;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in;
    logic [2:0]        ctrl;
    logic [DATA_W-1:0] a, b, c;
    logic              zero;
    logic              set_flags;
    logic [1:0]        br_type;
    logic [3:0]        cond;
    logic              valid_out;
    logic              branch_taken;
    logic [3:0]        flags_out;
    logic [CNT_W-1:0]  taken_count;
    logic              ctrl_err;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    logic             m_valid, m_taken, m_err;
    logic [3:0]       m_flags;
    int unsigned      m_count;

    alu_flag_branch_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ctrl(ctrl),
        .A(a), .B(b), .C(c), .zero(zero), .set_flags(set_flags),
        .br_type(br_type), .cond(cond), .valid_out(valid_out),
        .branch_taken(branch_taken), .flags_out(flags_out),
        .taken_count(taken_count), .ctrl_err(ctrl_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flags from the arithmetic meaning of each op, not from sign-bit equations
    function automatic logic [3:0] model_flags(input logic [2:0] op, input logic [63:0] x,
                                               input logic [63:0] y, input logic [63:0] r);
        logic [64:0] wide;
        logic signed [64:0] sw;
        logic cf, vf;
        cf = 1'b0; vf = 1'b0;
        if (op == 3'd0) begin
            wide = {1'b0, x} + {1'b0, y};
            cf = wide[64];
            sw = $signed({x[63], x}) + $signed({y[63], y});
            vf = sw[64] != sw[63];
        end else if (op == 3'd1) begin
            cf = (x >= y);
            sw = $signed({x[63], x}) - $signed({y[63], y});
            vf = sw[64] != sw[63];
        end
        return {r[63], (r == 64'd0), cf, vf};
    endfunction

    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (cc)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cf;         4'h3: return !cf;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cf && !z;   4'h9: return !(cf && !z);
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return !(!z && n == v);
            default: return 1'b1;
        endcase
    endfunction

    // Advance one clock; the model consumes the inputs held across the edge
    task automatic step();
        logic t;
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 0; m_taken = 0; m_flags = 0; m_count = 0; m_err = 0;
        end else begin
            t = 0;
            if (valid_in) begin
                if (br_type == 2'b01) t = zero;
                else if (br_type == 2'b10) t = !zero;
                else if (br_type == 2'b11) t = cond_holds(cond, m_flags);
            end
            m_valid = valid_in;
            m_taken = t;
            if (t && m_count < 65535) m_count++;
            if (valid_in && set_flags) begin
                if (ctrl <= 3'd4) m_flags = model_flags(ctrl, a, b, c);
                else m_err = 1;
            end
        end
    endtask

    task automatic op(input logic [2:0] op_c, input logic [63:0] x, input logic [63:0] y,
                      input logic sf, input logic [1:0] bt, input logic [3:0] cc);
        logic [63:0] r;
        case (op_c)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = y;
            default: r = 64'd0;
        endcase
        valid_in = 1; ctrl = op_c; a = x; b = y; c = r; zero = (r == 0);
        set_flags = sf; br_type = bt; cond = cc;
        step();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid_out", valid_out, m_valid);
            chk("branch_taken", branch_taken, m_taken);
            chk("flags_out", flags_out, m_flags);
            chk("taken_count", taken_count, m_count);
            chk("ctrl_err", ctrl_err, m_err);
        end
    end

    initial begin
        int guard;
        reset = 1; valid_in = 0; ctrl = 0; a = 0; b = 0; c = 0; zero = 0;
        set_flags = 0; br_type = 0; cond = 0;
        step();
        cmp_en = 1;
        step();
        reset = 0;
        chk("reset_flags", flags_out, 4'b0000);
        chk("reset_valid", valid_out, 1'b0);
        chk("reset_count", taken_count, 16'd0);

        op(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 2'b00, 4'h0);
        chk("adds_overflow_flags", flags_out, 4'b1001);
        chk("adds_err", ctrl_err, 1'b0);

        op(3'd1, 64'd5, 64'd5, 1, 2'b00, 4'h0);
        chk("subs_equal_flags", flags_out, 4'b0110);
        op(3'd0, 64'd0, 64'd0, 0, 2'b11, 4'h0);
        chk("beq_taken", branch_taken, 1'b1);
        chk("beq_valid", valid_out, 1'b1);
        op(3'd0, 64'd0, 64'd0, 0, 2'b11, 4'h1);
        chk("bne_taken", branch_taken, 1'b0);

        reset = 1; step(); reset = 0;
        op(3'd1, 64'd3, 64'd5, 1, 2'b11, 4'hA);
        chk("bge_old_flags", branch_taken, 1'b1);
        chk("subs_neg_flags", flags_out, 4'b1000);
        op(3'd0, 64'd1, 64'd1, 0, 2'b11, 4'hB);
        chk("blt_new_flags", branch_taken, 1'b1);

        op(3'd0, 64'd1, 64'd1, 0, 2'b10, 4'h0);
        chk("cbnz_nonzero", branch_taken, 1'b1);
        op(3'd0, 64'd1, 64'd1, 0, 2'b01, 4'h0);
        chk("cbz_nonzero", branch_taken, 1'b0);
        op(3'd0, 64'd0, 64'd0, 0, 2'b00, 4'h0);
        chk("br_none", branch_taken, 1'b0);
        chk("count_three", taken_count, 16'd3);

        // Sweep every condition code over several flag patterns
        op(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 2'b00, 4'h0);
        for (int cc = 0; cc < 16; cc++) op(3'd3, 64'd0, 64'd0, 0, 2'b11, cc[3:0]);
        op(3'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1, 2'b00, 4'h0);
        for (int cc = 0; cc < 16; cc++) op(3'd3, 64'd0, 64'd0, 0, 2'b11, cc[3:0]);
        op(3'd1, 64'd9, 64'd2, 1, 2'b00, 4'h0);
        for (int cc = 0; cc < 16; cc++) op(3'd3, 64'd0, 64'd0, 0, 2'b11, cc[3:0]);
        op(3'd2, 64'hF0, 64'h0F, 1, 2'b01, 4'h0);
        for (int cc = 0; cc < 16; cc++) op(3'd3, 64'd0, 64'd0, 0, 2'b11, cc[3:0]);
        op(3'd4, 64'd0, 64'h8000_0000_0000_0000, 1, 2'b00, 4'h0);
        chk("passb_flags", flags_out, 4'b1000);

        valid_in = 0; set_flags = 1; ctrl = 3'd1; br_type = 2'b11; cond = 4'hE; step();
        chk("idle_valid", valid_out, 1'b0);
        chk("idle_taken", branch_taken, 1'b0);

        op(3'b111, 64'd1, 64'd1, 1, 2'b00, 4'h0);
        chk("bad_ctrl_err", ctrl_err, 1'b1);
        chk("bad_ctrl_flags", flags_out, 4'b1000);
        op(3'd0, 64'd2, 64'd3, 1, 2'b00, 4'h0);
        chk("err_sticky", ctrl_err, 1'b1);

        guard = 0;
        while (m_count < 65535 && guard < 70000) begin
            op(3'd0, 64'd1, 64'd1, 0, 2'b10, 4'h0);
            guard++;
        end
        chk("count_reached_max", taken_count, 16'hFFFF);
        op(3'd0, 64'd1, 64'd1, 0, 2'b11, 4'hF);
        chk("count_saturates", taken_count, 16'hFFFF);

        reset = 1;
        op(3'd1, 64'd3, 64'd5, 1, 2'b10, 4'h0);
        reset = 0;
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_taken", branch_taken, 1'b0);
        chk("rst_flags", flags_out, 4'b0000);
        chk("rst_count", taken_count, 16'd0);
        chk("rst_err", ctrl_err, 1'b0);
        valid_in = 0;
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
